// File: rtl/axis_spm_dac_serializer.sv
// Purpose: final SPM output stage. Sums Z with slope (saturating), rounds and clips X/Y/Z/U to DAC codes, shifts four SPI words out in parallel, then strobes LDAC.
// Latency: inputs are sampled in the LATCH cycle. The period is 104 a_clk per frame at default parameters (IDLE 1 + LATCH 1 + SHIFT 96 + GAP 4 + LDAC 2).
// Backpressure: none is asserted upstream. A frame starts only when init_done, enable and all five tvalid are high in IDLE; tdata is ignored otherwise.
// Ports: a_clk/a_resetn; S_AXIS_{X,Y,Z,Z_SLOPE,U}_tdata/_tvalid (Q31 signed); enable;
//        dac_sclk/dac_sync_n/dac_mosi[3:0]/dac_ldac_n (SPI, mosi [0]=X [1]=Y [2]=Z [3]=U);
//        busy, init_done, frame_pulse, frame_count, sat_flags (status).
module axis_spm_dac_serializer #(
    parameter int                  DAC_BITS  = 20,
    parameter int                  SCLK_DIV  = 2,
    parameter int                  CS_GAP    = 4,
    parameter int                  LDAC_W    = 2,
    parameter logic [DAC_BITS+3:0] INIT_WORD = 24'h200002
) (
    input  logic        a_clk,
    input  logic        a_resetn,
    input  logic [31:0] S_AXIS_X_tdata,
    input  logic        S_AXIS_X_tvalid,
    input  logic [31:0] S_AXIS_Y_tdata,
    input  logic        S_AXIS_Y_tvalid,
    input  logic [31:0] S_AXIS_Z_tdata,
    input  logic        S_AXIS_Z_tvalid,
    input  logic [31:0] S_AXIS_Z_SLOPE_tdata,
    input  logic        S_AXIS_Z_SLOPE_tvalid,
    input  logic [31:0] S_AXIS_U_tdata,
    input  logic        S_AXIS_U_tvalid,
    input  logic        enable,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic [3:0]  dac_mosi,
    output logic        dac_ldac_n,
    output logic        busy,
    output logic        init_done,
    output logic        frame_pulse,
    output logic [31:0] frame_count,
    output logic [3:0]  sat_flags
);

    localparam int WORD_W = DAC_BITS + 4;
    localparam int SH     = 32 - DAC_BITS;

    localparam logic        [15:0] DIV_M1    = 16'(SCLK_DIV - 1);
    localparam logic        [15:0] TICK_LAST = 16'(2 * SCLK_DIV - 1);
    localparam logic        [15:0] GAP_LAST  = 16'(CS_GAP - 1);
    localparam logic        [15:0] LDAC_LAST = 16'(LDAC_W - 1);
    localparam logic        [4:0]  BIT_LAST  = 5'(WORD_W - 1);

    // Half an LSB of the DAC code, added before truncation for round-half-up.
    localparam logic signed [32:0] RND  = 33'sd1 <<< (31 - DAC_BITS);
    localparam logic signed [32:0] CMAX = (33'sd1 <<< (DAC_BITS - 1)) - 33'sd1;
    localparam logic signed [32:0] ZMAX = 33'sh0_7FFF_FFFF;
    localparam logic signed [32:0] ZMIN = -ZMAX;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_GAP,
        ST_LDAC
    } state_t;

    state_t                   state_q, state_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [4:0]               bit_q, bit_d;
    logic [3:0][WORD_W-1:0]   sr_q, sr_d;
    logic                     is_init_q, is_init_d;
    logic                     init_done_q, init_done_d;
    logic                     frame_pulse_q, frame_pulse_d;
    logic [31:0]              frame_count_q, frame_count_d;
    logic [3:0]               sat_q, sat_d;
    logic                     busy_q, busy_d;

    // ------------------------------------------------------------------
    // Datapath: Z + slope saturation, rounding and positive clipping.
    // ------------------------------------------------------------------
    logic signed [32:0]       z_sum;
    logic [31:0]              z_trim;
    logic                     z_sat;
    logic [3:0][31:0]         ch_in;
    logic signed [32:0]       rnd    [4];
    logic signed [32:0]       code33 [4];
    logic [3:0]               clip;
    logic [3:0][WORD_W-1:0]   lat_word;
    logic [3:0]               lat_sat;
    logic                     all_vld;

    // Symmetric clip to +/-(2^31-1); -2^31 counts as saturated as well.
    always_comb begin
        z_sum  = {S_AXIS_Z_tdata[31], S_AXIS_Z_tdata} + {S_AXIS_Z_SLOPE_tdata[31], S_AXIS_Z_SLOPE_tdata};
        z_trim = z_sum[31:0];
        z_sat  = 1'b0;
        if (z_sum > ZMAX) begin
            z_trim = ZMAX[31:0];
            z_sat  = 1'b1;
        end else if (z_sum < ZMIN) begin
            z_trim = ZMIN[31:0];
            z_sat  = 1'b1;
        end
    end

    assign ch_in = {S_AXIS_U_tdata, z_trim, S_AXIS_Y_tdata, S_AXIS_X_tdata};

    // Rounding can only carry upward, so only the positive limit needs a clip.
    always_comb begin
        clip     = '0;
        lat_word = '0;
        for (int i = 0; i < 4; i++) begin
            rnd[i]    = $signed({ch_in[i][31], ch_in[i]}) + RND;
            code33[i] = rnd[i] >>> SH;
            if (code33[i] > CMAX) begin
                clip[i]     = 1'b1;
                lat_word[i] = {4'b0001, CMAX[DAC_BITS-1:0]};
            end else begin
                lat_word[i] = {4'b0001, code33[i][DAC_BITS-1:0]};
            end
        end
        lat_sat = clip | {1'b0, z_sat, 2'b00};
    end

    assign all_vld = S_AXIS_X_tvalid & S_AXIS_Y_tvalid & S_AXIS_Z_tvalid &
                     S_AXIS_Z_SLOPE_tvalid & S_AXIS_U_tvalid;

    // ------------------------------------------------------------------
    // Frame sequencer.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        sr_d          = sr_q;
        is_init_d     = is_init_q;
        init_done_d   = init_done_q;
        frame_pulse_d = 1'b0;
        frame_count_d = frame_count_q;
        sat_d         = sat_q;

        case (state_q)
            ST_INIT: begin
                sr_d      = {4{INIT_WORD}};
                is_init_d = 1'b1;
                cnt_d     = '0;
                bit_d     = '0;
                state_d   = ST_SHIFT;
            end
            ST_IDLE: begin
                if (init_done_q && enable && all_vld) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                sr_d    = lat_word;
                sat_d   = lat_sat;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // cnt_q walks one SCLK period: high half first, then low half.
                // The shift at the end of the low half makes mosi change together
                // with the rising SCLK of the next bit.
                if (cnt_q == TICK_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < 4; i++) begin
                        sr_d[i] = {sr_q[i][WORD_W-2:0], 1'b0};
                    end
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (is_init_q) begin
                        // Control-register frame: no output update needed.
                        is_init_d   = 1'b0;
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_LDAC;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_LDAC: begin
                if (cnt_q == LDAC_LAST) begin
                    cnt_d         = '0;
                    frame_pulse_d = 1'b1;
                    frame_count_d = frame_count_q + 32'd1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Registered copy so busy reads low while reset is held.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            bit_q         <= '0;
            sr_q          <= '0;
            is_init_q     <= 1'b0;
            init_done_q   <= 1'b0;
            frame_pulse_q <= 1'b0;
            frame_count_q <= '0;
            sat_q         <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            sr_q          <= sr_d;
            is_init_q     <= is_init_d;
            init_done_q   <= init_done_d;
            frame_pulse_q <= frame_pulse_d;
            frame_count_q <= frame_count_d;
            sat_q         <= sat_d;
            busy_q        <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // SPI pins: decoded from registered state, so reset forces idle levels at once.
    // ------------------------------------------------------------------
    always_comb begin
        dac_sync_n = (state_q != ST_SHIFT);
        dac_sclk   = (state_q != ST_SHIFT) || (cnt_q <= DIV_M1);
        dac_ldac_n = (state_q != ST_LDAC);
        dac_mosi   = '0;
        if (state_q == ST_SHIFT) begin
            for (int i = 0; i < 4; i++) begin
                dac_mosi[i] = sr_q[i][WORD_W-1];
            end
        end
    end

    assign busy        = busy_q;
    assign init_done   = init_done_q;
    assign frame_pulse = frame_pulse_q;
    assign frame_count = frame_count_q;
    assign sat_flags   = sat_q;

endmodule
